// File: rtl/mul_div_iter_pkg.sv
// Shared op and state encodings for the iterative multiply/divide unit.
// The CPU control unit imports the same op constants when it issues start.
package mul_div_iter_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_SIGN = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef struct packed {
        logic is_div;
        logic is_signed;
    } md_op_t;

    function automatic md_op_t decode_op(input logic [1:0] op);
        md_op_t d;
        d.is_div    = (op == OP_DIVU) || (op == OP_DIV);
        d.is_signed = (op == OP_MULT) || (op == OP_DIV);
        return d;
    endfunction

endpackage

// File: rtl/mul_div_iter_abs_neg.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix-up.
module md_abs_neg
    import mul_div_iter_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic             neg,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = neg ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
    end

endmodule

// File: rtl/mul_div_iter.sv
// Iterative WIDTH-bit multiply/divide unit: shift-add multiply and restoring divide
// sharing one (WIDTH+1)-bit adder, with a registered HI/LO result and a done strobe.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for start; operands, magnitudes and signs latched here
// ST_CALC | one multiply or divide iteration per edge, count runs down to 0
// ST_SIGN | apply result signs and write HI/LO
// ST_DONE | done strobe for one cycle, busy still high
module mul_div_iter
    import mul_div_iter_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [1:0]         state_r;
    logic               div_r;
    logic               res_neg_r;
    logic               rem_neg_r;
    logic [CNT_W-1:0]   count_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   b_r;

    md_op_t             op_dec;
    logic               a_neg;
    logic               b_neg;
    logic               div_by_zero;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    logic [WIDTH:0]     add_a;
    logic [WIDTH:0]     add_b;
    logic               add_cin;
    logic [WIDTH:0]     add_sum;
    logic               q_bit;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    always_comb begin
        op_dec      = decode_op(op);
        a_neg       = op_dec.is_signed & A[WIDTH-1];
        b_neg       = op_dec.is_signed & B[WIDTH-1];
        div_by_zero = op_dec.is_div & (B == '0);
    end

    // Most-negative input yields 2^(WIDTH-1), which fits the unsigned magnitude.
    md_abs_neg #(.WIDTH(WIDTH)) u_abs_a (.neg(a_neg), .a(A), .y(mag_a));
    md_abs_neg #(.WIDTH(WIDTH)) u_abs_b (.neg(b_neg), .a(B), .y(mag_b));

    // Divide: trial subtract of the divisor from the shifted partial remainder.
    // Multiply: add the multiplicand into the upper half when the low multiplier bit is set.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (div_r) begin
            add_a   = {hi_r, lo_r[WIDTH-1]};
            add_b   = ~{1'b0, b_r};
            add_cin = 1'b1;
        end else begin
            add_a   = {1'b0, hi_r};
            add_b   = lo_r[0] ? {1'b0, b_r} : '0;
        end
        add_sum = add_a + add_b + {{WIDTH{1'b0}}, add_cin};
        q_bit   = ~add_sum[WIDTH];
    end

    // The low half of a 2W negate equals the W-bit negate, so the quotient reuses it.
    md_abs_neg #(.WIDTH(2*WIDTH)) u_fix_prod (.neg(res_neg_r), .a({hi_r, lo_r}), .y(prod_fix));
    md_abs_neg #(.WIDTH(WIDTH))   u_fix_rem  (.neg(rem_neg_r), .a(hi_r),         .y(rem_fix));

    always_comb begin
        res_hi = div_r ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        res_lo = prod_fix[WIDTH-1:0];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            div_r     <= 1'b0;
            res_neg_r <= 1'b0;
            rem_neg_r <= 1'b0;
            count_r   <= '0;
            hi_r      <= '0;
            lo_r      <= '0;
            b_r       <= '0;
            HI        <= '0;
            LO        <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (div_by_zero) begin
                            HI      <= A;
                            LO      <= '1;
                            state_r <= ST_DONE;
                        end else begin
                            div_r     <= op_dec.is_div;
                            res_neg_r <= a_neg ^ b_neg;
                            rem_neg_r <= a_neg;
                            hi_r      <= '0;
                            lo_r      <= mag_a;
                            b_r       <= mag_b;
                            count_r   <= CNT_W'(WIDTH-1);
                            state_r   <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (div_r) begin
                        hi_r <= q_bit ? add_sum[WIDTH-1:0] : add_a[WIDTH-1:0];
                        lo_r <= {lo_r[WIDTH-2:0], q_bit};
                    end else begin
                        hi_r <= add_sum[WIDTH:1];
                        lo_r <= {add_sum[0], lo_r[WIDTH-1:1]};
                    end
                    if (count_r == '0) begin
                        state_r <= ST_SIGN;
                    end else begin
                        count_r <= count_r - 1'b1;
                    end
                end
                ST_SIGN: begin
                    HI      <= res_hi;
                    LO      <= res_lo;
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy = (state_r != ST_IDLE);
        done = (state_r == ST_DONE);
    end

endmodule
